// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the fetch line responder slice.
//   - refill FSM state encoding
//   - default address / instruction widths
//   - clog2() used to size the line offset field
package cpu_fetch_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    WAIT = 2'd2
  } fetchState_e;

  function automatic int clog2(input int n);
    for (int r = 0; r < 32; r++)
      if ((1 << r) >= n) return r;
    return 32;
  endfunction
endpackage

// File: rtl/fetch_line_responder_if.sv
// Fetch-side and backing-memory-side signals of the fetch line responder.
//   slave  : responder view (fetch request/flush and memory replies in,
//            instruction/stall and memory request out)
//   master : environment view (fetch stage + backing memory)
interface fetch_line_responder_if
  import cpu_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              flush;
  logic [DATA_W-1:0] instr;
  logic              fetch_stall;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rdy;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, flush, mem_rdy, mem_rvalid, mem_rdata,
    output instr, fetch_stall, mem_rd, mem_addr
  );

  modport master (
    output fetch_req, fetch_addr, flush, mem_rdy, mem_rvalid, mem_rdata,
    input  instr, fetch_stall, mem_rd, mem_addr
  );
endinterface

// File: rtl/fetch_line_buf.sv
// Line storage: LINE_WORDS x DATA_W registers.
//   clk, rst     : clock, async active-low reset (clears contents)
//   we/wrIdx/wrData : single write port
//   rdIdx/rdData : combinational read port
module fetch_line_buf
  import cpu_fetch_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int IDX_W      = clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  wrIdx,
  input  logic [DATA_W-1:0] wrData,
  input  logic [IDX_W-1:0]  rdIdx,
  output logic [DATA_W-1:0] rdData
);
  logic [LINE_WORDS-1:0][DATA_W-1:0] words;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words <= '0;
    end else if (we) begin
      words[wrIdx] <= wrData;
    end
  end

  assign rdData = words[rdIdx];
endmodule

// File: rtl/fetch_line_responder.sv
// Single-line instruction responder between the fetch stage and a slower
// backing instruction memory. Hits are served combinationally; a miss
// stalls fetch and refills the whole line one word at a time with exactly
// one backing read outstanding.
//   clk, rst : clock, async active-low reset
//   bus      : fetch_line_responder_if.slave (fetch + backing memory signals)
//   hit_cnt, miss_cnt : saturating perf counters, only when
//                       FETCH_PERF_CNT_EN is defined
module fetch_line_responder
  import cpu_fetch_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_line_responder_if.slave  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]            hit_cnt,
  output logic [15:0]            miss_cnt
`endif
);
  localparam int OFF_W = clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  fetchState_e       state, nextState;
  logic              lineValid;
  logic [TAG_W-1:0]  lineTag;   // tag of the line held or being refilled
  logic [OFF_W-1:0]  beat;
  logic              killed;    // flush seen while a read is in flight
  logic [TAG_W-1:0]  fetchTag;
  logic              hit;
  logic              startMiss;
  logic              wordWe;
  logic              lineDone;
  logic [DATA_W-1:0] rdData;

  assign fetchTag = bus.fetch_addr[ADDR_W-1:OFF_W];
  assign hit      = lineValid && (fetchTag == lineTag);
  assign bus.instr = hit ? rdData : '0;

  always_comb begin
    nextState       = state;
    bus.fetch_stall = 1'b0;
    bus.mem_rd      = 1'b0;
    bus.mem_addr    = '0;
    startMiss       = 1'b0;
    wordWe          = 1'b0;
    lineDone        = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.fetch_req && !hit) begin
          bus.fetch_stall = 1'b1;
          // a flush in the same cycle wins; the miss is retried next cycle
          if (!bus.flush) begin
            startMiss = 1'b1;
            nextState = FILL;
          end
        end
      end
      FILL: begin
        bus.fetch_stall = 1'b1;
        // flush withdraws the request before it can be accepted
        bus.mem_rd   = !bus.flush;
        bus.mem_addr = {lineTag, {OFF_W{1'b0}}} + ADDR_W'(beat);
        if (bus.flush)        nextState = IDLE;
        else if (bus.mem_rdy) nextState = WAIT;
      end
      WAIT: begin
        bus.fetch_stall = 1'b1;
        if (bus.mem_rvalid) begin
          if (killed || bus.flush) begin
            nextState = IDLE;
          end else begin
            wordWe = 1'b1;
            if (beat == LAST_BEAT) begin
              lineDone  = 1'b1;
              nextState = IDLE;
            end else begin
              nextState = FILL;
            end
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lineValid <= 1'b0;
      lineTag   <= '0;
      beat      <= '0;
      killed    <= 1'b0;
    end else begin
      state  <= nextState;
      killed <= (state == WAIT) && !bus.mem_rvalid && (killed || bus.flush);
      if (startMiss) begin
        lineTag   <= fetchTag;
        beat      <= '0;
        lineValid <= 1'b0;
      end
      if (wordWe)   beat      <= beat + OFF_W'(1);
      if (lineDone) lineValid <= 1'b1;
      if (bus.flush) lineValid <= 1'b0;  // beats a simultaneous completion
    end
  end

  fetch_line_buf #(
    .LINE_WORDS(LINE_WORDS),
    .DATA_W    (DATA_W)
  ) uLineBuf (
    .clk   (clk),
    .rst   (rst),
    .we    (wordWe),
    .wrIdx (beat),
    .wrData(bus.mem_rdata),
    .rdIdx (bus.fetch_addr[OFF_W-1:0]),
    .rdData(rdData)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (bus.flush) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (state == IDLE && bus.fetch_req && hit && hit_cnt != 16'hFFFF)
        hit_cnt <= hit_cnt + 16'd1;
      if (startMiss && miss_cnt != 16'hFFFF)
        miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_line_responder.sv
// Directed bench for fetch_line_responder. Backing memory returns
// {addr[7:0], ~addr[7:0]} one cycle (plus rvDelay) after accept.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_fetch_line_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_line_responder_if bus ();
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  fetch_line_responder dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .hit_cnt (hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  int nCmp = 0;
  int nBad = 0;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return {a[7:0], ~a[7:0]};
  endfunction

  // backing memory model
  int          pendCnt = 0;
  int          rvDelay = 0;
  logic [15:0] pendAddr = '0;
  logic        injectRv = 1'b0;
  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (pendCnt == 1) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = memWord(pendAddr);
        pendCnt = 0;
      end else begin
        if (pendCnt > 1) pendCnt--;
        if (injectRv) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = 16'hDEAD;
          injectRv = 1'b0;
        end else begin
          bus.mem_rvalid = 1'b0;
        end
      end
      #2;
      if (!rst) pendCnt = 0;
      else if (bus.mem_rd && bus.mem_rdy) begin
        pendCnt  = 1 + rvDelay;
        pendAddr = bus.mem_addr;
      end
    end
  end

  logic [15:0] addrLog [16];

  // run cycles until fetch_stall drops; logs accepted read addresses
  task automatic wait_unstall(output int stalls, output int nRd, output logic timedOut);
    stalls = 0; nRd = 0; timedOut = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (bus.fetch_stall) begin
        stalls++;
        if (bus.mem_rd && bus.mem_rdy && nRd < 16) begin
          addrLog[nRd] = bus.mem_addr;
          nRd++;
        end
      end else begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.flush = 1'b0; bus.mem_rdy = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    nCmp++; if (bus.fetch_stall !== 1'b0) begin nBad++; $display("FAIL rst_stall: got %b want 0", bus.fetch_stall); end
    nCmp++; if (bus.mem_rd !== 1'b0) begin nBad++; $display("FAIL rst_mem_rd: got %b want 0", bus.mem_rd); end
    nCmp++; if (bus.mem_addr !== 16'h0000) begin nBad++; $display("FAIL rst_mem_addr: got %h want 0000", bus.mem_addr); end
    nCmp++; if (bus.instr !== 16'h0000) begin nBad++; $display("FAIL rst_instr: got %h want 0000", bus.instr); end
`ifdef FETCH_PERF_CNT_EN
    nCmp++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin nBad++; $display("FAIL rst_cnt: got %h/%h want 0/0", hit_cnt, miss_cnt); end
`endif
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    nCmp++; if (bus.mem_rd !== 1'b0 || bus.fetch_stall !== 1'b0) begin nBad++; $display("FAIL idle_noreq: got rd=%b stall=%b want 0/0", bus.mem_rd, bus.fetch_stall); end
  endtask

  task automatic test_cold_fill;
    int st, nr; logic to;
    @(negedge clk); bus.fetch_req = 1'b1; bus.fetch_addr = 16'h0000; #1;
    nCmp++; if (bus.fetch_stall !== 1'b1) begin nBad++; $display("FAIL cold_stall0: got %b want 1", bus.fetch_stall); end
    wait_unstall(st, nr, to);
    nCmp++; if (to) begin nBad++; $display("FAIL cold_timeout: got stuck want unstall"); end
    nCmp++; if (st != 8) begin nBad++; $display("FAIL cold_stall_cycles: got %0d want 8", st); end
    nCmp++; if (nr != 4 || addrLog[0] !== 16'h0000 || addrLog[1] !== 16'h0001 || addrLog[2] !== 16'h0002 || addrLog[3] !== 16'h0003)
      begin nBad++; $display("FAIL cold_addr_seq: got n=%0d %h %h %h %h want 4 0000 0001 0002 0003", nr, addrLog[0], addrLog[1], addrLog[2], addrLog[3]); end
    nCmp++; if (bus.instr !== 16'h00FF) begin nBad++; $display("FAIL cold_instr: got %h want 00ff", bus.instr); end
  endtask

  task automatic test_seq_hits;
    logic [15:0] expInstr [3];
    expInstr[0] = 16'h01FE; expInstr[1] = 16'h02FD; expInstr[2] = 16'h03FC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.fetch_addr = 16'(i + 1); #1;
      nCmp++; if (bus.fetch_stall !== 1'b0 || bus.mem_rd !== 1'b0 || bus.instr !== expInstr[i])
        begin nBad++; $display("FAIL hit_%0d: got stall=%b rd=%b instr=%h want 0 0 %h", i + 1, bus.fetch_stall, bus.mem_rd, bus.instr, expInstr[i]); end
    end
  endtask

  task automatic test_miss_new_line;
    int st, nr; logic to;
    @(negedge clk); bus.fetch_addr = 16'h0005; #1;
    nCmp++; if (bus.fetch_stall !== 1'b1) begin nBad++; $display("FAIL miss5_stall: got %b want 1", bus.fetch_stall); end
    wait_unstall(st, nr, to);
    nCmp++; if (to || st != 8 || nr != 4 || addrLog[0] !== 16'h0004 || addrLog[3] !== 16'h0007)
      begin nBad++; $display("FAIL miss5_fill: got to=%b st=%0d n=%0d first=%h last=%h want 0 8 4 0004 0007", to, st, nr, addrLog[0], addrLog[3]); end
    nCmp++; if (bus.instr !== 16'h05FA) begin nBad++; $display("FAIL miss5_instr: got %h want 05fa", bus.instr); end
    @(negedge clk); bus.fetch_addr = 16'h0000; #1;
    nCmp++; if (bus.fetch_stall !== 1'b1) begin nBad++; $display("FAIL old_line_miss: got %b want 1", bus.fetch_stall); end
    wait_unstall(st, nr, to);
    nCmp++; if (to || bus.instr !== 16'h00FF) begin nBad++; $display("FAIL refill0_instr: got to=%b %h want 0 00ff", to, bus.instr); end
  endtask

  task automatic test_flush_wait;
    int st, nr; logic to; logic found;
    found = 1'b0; rvDelay = 2;
    @(negedge clk); bus.fetch_addr = 16'h0004;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk); #1;
      if (bus.mem_rd && bus.mem_addr == 16'h0006) found = 1'b1;
    end
    nCmp++; if (!found) begin nBad++; $display("FAIL flush_reach_beat2: got none want read of 0006"); end
    @(negedge clk); bus.flush = 1'b1; #1;
    nCmp++; if (bus.fetch_stall !== 1'b1) begin nBad++; $display("FAIL flush_wait_stall: got %b want 1", bus.fetch_stall); end
    @(negedge clk); bus.flush = 1'b0; #1;
    nCmp++; if (bus.fetch_stall !== 1'b1 || bus.mem_rd !== 1'b0) begin nBad++; $display("FAIL flush_hold_wait: got stall=%b rd=%b want 1 0", bus.fetch_stall, bus.mem_rd); end
    @(negedge clk); #1;
    nCmp++; if (bus.fetch_stall !== 1'b1 || bus.mem_rd !== 1'b0) begin nBad++; $display("FAIL flush_rvalid_cycle: got stall=%b rd=%b want 1 0", bus.fetch_stall, bus.mem_rd); end
    @(negedge clk); bus.fetch_req = 1'b0; rvDelay = 0; #1;
    nCmp++; if (bus.fetch_stall !== 1'b0 || bus.mem_rd !== 1'b0 || bus.instr !== 16'h0000)
      begin nBad++; $display("FAIL flush_idle_invalid: got stall=%b rd=%b instr=%h want 0 0 0000", bus.fetch_stall, bus.mem_rd, bus.instr); end
    @(negedge clk); bus.fetch_req = 1'b1; #1;
    nCmp++; if (bus.fetch_stall !== 1'b1) begin nBad++; $display("FAIL flush_remiss: got %b want 1", bus.fetch_stall); end
    wait_unstall(st, nr, to);
    nCmp++; if (to || st != 8 || nr != 4 || addrLog[0] !== 16'h0004 || addrLog[3] !== 16'h0007 || bus.instr !== 16'h04FB)
      begin nBad++; $display("FAIL flush_refill: got to=%b st=%0d n=%0d %h..%h instr=%h want 0 8 4 0004..0007 04fb", to, st, nr, addrLog[0], addrLog[3], bus.instr); end
  endtask

  task automatic test_redirect;
    int st, nr; logic to;
    @(negedge clk); bus.fetch_addr = 16'h0020; #1;
    @(negedge clk); #1;
    nCmp++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0020) begin nBad++; $display("FAIL redir_first_rd: got rd=%b addr=%h want 1 0020", bus.mem_rd, bus.mem_addr); end
    @(negedge clk); bus.fetch_addr = 16'h0031; #1;
    wait_unstall(st, nr, to);
    nCmp++; if (to || st != 15 || nr != 7 || addrLog[0] !== 16'h0021 || addrLog[2] !== 16'h0023 || addrLog[3] !== 16'h0030 || addrLog[6] !== 16'h0033)
      begin nBad++; $display("FAIL redir_seq: got to=%b st=%0d n=%0d %h %h %h %h want 0 15 7 0021 0023 0030 0033", to, st, nr, addrLog[0], addrLog[2], addrLog[3], addrLog[6]); end
    nCmp++; if (bus.instr !== 16'h31CE) begin nBad++; $display("FAIL redir_instr: got %h want 31ce", bus.instr); end
  endtask

  task automatic test_top_line;
    int st, nr; logic to;
    @(negedge clk); bus.fetch_addr = 16'hFFFE; #1;
    wait_unstall(st, nr, to);
    nCmp++; if (to || nr != 4 || addrLog[0] !== 16'hFFFC || addrLog[1] !== 16'hFFFD || addrLog[2] !== 16'hFFFE || addrLog[3] !== 16'hFFFF)
      begin nBad++; $display("FAIL top_line_addrs: got n=%0d %h %h %h %h want 4 fffc fffd fffe ffff", nr, addrLog[0], addrLog[1], addrLog[2], addrLog[3]); end
    nCmp++; if (bus.instr !== 16'hFE01) begin nBad++; $display("FAIL top_line_instr: got %h want fe01", bus.instr); end
  endtask

  task automatic test_reset_mid_fill;
    int st, nr; logic to;
    @(negedge clk); bus.mem_rdy = 1'b0; bus.fetch_addr = 16'h0010;
    repeat (5) @(negedge clk);
    #1;
    nCmp++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0010) begin nBad++; $display("FAIL rdy_hold: got rd=%b addr=%h want 1 0010", bus.mem_rd, bus.mem_addr); end
    @(negedge clk); bus.fetch_req = 1'b0;
    #3 rst = 1'b0;
    #1;
    nCmp++; if (bus.mem_rd !== 1'b0 || bus.fetch_stall !== 1'b0 || bus.mem_addr !== 16'h0000)
      begin nBad++; $display("FAIL async_rst: got rd=%b stall=%b addr=%h want 0 0 0000", bus.mem_rd, bus.fetch_stall, bus.mem_addr); end
    @(negedge clk); rst = 1'b1; bus.mem_rdy = 1'b1; #1 injectRv = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    nCmp++; if (bus.mem_rd !== 1'b0 || bus.fetch_stall !== 1'b0 || bus.instr !== 16'h0000)
      begin nBad++; $display("FAIL late_rvalid: got rd=%b stall=%b instr=%h want 0 0 0000", bus.mem_rd, bus.fetch_stall, bus.instr); end
    @(negedge clk); bus.fetch_req = 1'b1; #1;
    wait_unstall(st, nr, to);
    nCmp++; if (to || st != 8 || nr != 4 || addrLog[0] !== 16'h0010 || addrLog[3] !== 16'h0013 || bus.instr !== 16'h10EF)
      begin nBad++; $display("FAIL post_rst_fill: got to=%b st=%0d n=%0d %h..%h instr=%h want 0 8 4 0010..0013 10ef", to, st, nr, addrLog[0], addrLog[3], bus.instr); end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_cnt;
    int st, nr; logic to;
    @(negedge clk); bus.fetch_req = 1'b0; bus.flush = 1'b1;
    @(negedge clk); bus.flush = 1'b0; #1;
    nCmp++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin nBad++; $display("FAIL cnt_clear0: got %h/%h want 0/0", hit_cnt, miss_cnt); end
    @(negedge clk); bus.fetch_req = 1'b1; bus.fetch_addr = 16'h0040; #1;
    wait_unstall(st, nr, to);
    @(negedge clk); bus.fetch_addr = 16'h0041;
    @(negedge clk); bus.fetch_addr = 16'h0042;
    @(negedge clk); bus.fetch_req = 1'b0; #1;
    nCmp++; if (hit_cnt !== 16'd3 || miss_cnt !== 16'd1) begin nBad++; $display("FAIL cnt_vals: got hit=%0d miss=%0d want 3 1", hit_cnt, miss_cnt); end
    @(negedge clk); bus.flush = 1'b1;
    @(negedge clk); bus.flush = 1'b0; #1;
    nCmp++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin nBad++; $display("FAIL cnt_flush: got %h/%h want 0/0", hit_cnt, miss_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_fill();
    test_seq_hits();
    test_miss_new_line();
    test_flush_wait();
    test_redirect();
    test_top_line();
    test_reset_mid_fill();
`ifdef FETCH_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
